// File: rtl/sopc4_mem_pkg.sv
// Shared constants and types for the two-requester on-chip memory arbiter.
package sopc4_mem_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int BE_W      = DATA_W / 8;
  localparam int DEPTH     = 51200;
  localparam int ERR_CNT_W = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
  } req_t;

  typedef struct packed {
    logic valid;
    logic owner;
    logic oor;
  } rd_pend_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return {{(32-ADDR_W){1'b0}}, addr} < 32'(DEPTH);
  endfunction

endpackage

// File: rtl/sopc4_rr_arbiter2.sv
// Two-way round-robin grant; on contention the requester not granted last wins.
module sopc4_rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic rr_last_q;
  logic rr_last_d;

  always_comb begin
    gnt       = 2'b00;
    rr_last_d = rr_last_q;
    if (en) begin
      if (req == 2'b11) gnt = rr_last_q ? 2'b01 : 2'b10;
      else              gnt = req;
    end
    if (gnt != 2'b00) rr_last_d = gnt[1];
  end

  // Reset to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) rr_last_q <= 1'b1;
    else       rr_last_q <= rr_last_d;
  end

endmodule

// File: rtl/sopc4_memory_arbiter.sv
// Avalon-MM arbiter in front of a single-port on-chip RAM with one-cycle read
// latency; rejects out-of-range word addresses and counts them.
module sopc4_memory_arbiter
  import sopc4_mem_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_W-1:0]    m0_address,
  input  logic [BE_W-1:0]      m0_byteenable,
  input  logic                 m0_read,
  input  logic                 m0_write,
  input  logic [DATA_W-1:0]    m0_writedata,
  output logic                 m0_waitrequest,
  output logic [DATA_W-1:0]    m0_readdata,
  output logic                 m0_readdatavalid,
  input  logic [ADDR_W-1:0]    m1_address,
  input  logic [BE_W-1:0]      m1_byteenable,
  input  logic                 m1_read,
  input  logic                 m1_write,
  input  logic [DATA_W-1:0]    m1_writedata,
  output logic                 m1_waitrequest,
  output logic [DATA_W-1:0]    m1_readdata,
  output logic                 m1_readdatavalid,
  output logic [ADDR_W-1:0]    mem_address,
  output logic [BE_W-1:0]      mem_byteenable,
  output logic                 mem_chipselect,
  output logic                 mem_write,
  output logic [DATA_W-1:0]    mem_writedata,
  output logic                 mem_clken,
  input  logic [DATA_W-1:0]    mem_readdata,
  input  logic                 stall,
  output logic                 err_flag,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 err_clear
);

  // Handshake: a requester presents read or write (write wins if both) and
  // holds it; the transfer is accepted in the cycle its waitrequest is 0.
  // Read data returns exactly one cycle after acceptance with readdatavalid.
  req_t                 r0, r1, win;
  logic [1:0]           req, gnt;
  logic                 granted, oor, rdv_ok;
  logic [DATA_W-1:0]    rdata;
  logic [ADDR_W-1:0]    mem_address_q, mem_address_d;
  rd_pend_t             rd_pend_q, rd_pend_d;
  logic                 err_flag_q, err_flag_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  always_comb begin
    r0 = '{address: m0_address, byteenable: m0_byteenable, read: m0_read,
           write: m0_write, writedata: m0_writedata};
    r1 = '{address: m1_address, byteenable: m1_byteenable, read: m1_read,
           write: m1_write, writedata: m1_writedata};
    req = {m1_read | m1_write, m0_read | m0_write};
  end

  sopc4_rr_arbiter2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .en    (~stall & ~reset),
    .gnt   (gnt)
  );

  always_comb begin
    win     = gnt[1] ? r1 : r0;
    granted = |gnt;
    oor     = ~in_range(win.address);

    mem_address_d = granted ? win.address : mem_address_q;

    rd_pend_d.valid = granted & win.read & ~win.write;
    rd_pend_d.owner = gnt[1];
    rd_pend_d.oor   = oor;

    // Clear beats a same-cycle out-of-range access.
    err_flag_d  = err_flag_q;
    err_count_d = err_count_q;
    if (err_clear) begin
      err_flag_d  = 1'b0;
      err_count_d = '0;
    end else if (granted && oor) begin
      err_flag_d = 1'b1;
      if (err_count_q != '1) err_count_d = err_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_address_q <= '0;
      rd_pend_q     <= '0;
      err_flag_q    <= 1'b0;
      err_count_q   <= '0;
    end else begin
      mem_address_q <= mem_address_d;
      rd_pend_q     <= rd_pend_d;
      err_flag_q    <= err_flag_d;
      err_count_q   <= err_count_d;
    end
  end

  assign m0_waitrequest = ~gnt[0];
  assign m1_waitrequest = ~gnt[1];

  assign mem_address    = mem_address_d;
  assign mem_byteenable = win.byteenable;
  assign mem_writedata  = win.writedata;
  assign mem_chipselect = granted & ~oor;
  assign mem_write      = granted & ~oor & win.write;
  assign mem_clken      = ~stall | rd_pend_q.valid;

  // Gating with reset drops a return that would land in the reset cycle.
  assign rdv_ok = rd_pend_q.valid & ~reset;
  assign rdata  = rd_pend_q.oor ? '0 : mem_readdata;

  assign m0_readdatavalid = rdv_ok & ~rd_pend_q.owner;
  assign m1_readdatavalid = rdv_ok &  rd_pend_q.owner;
  assign m0_readdata      = m0_readdatavalid ? rdata : '0;
  assign m1_readdata      = m1_readdatavalid ? rdata : '0;

  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_sopc4_memory_arbiter.sv
// Directed vector bench for sopc4_memory_arbiter with a behavioural RAM model.
module tb_sopc4_memory_arbiter;
  import sopc4_mem_pkg::*;

  localparam bit [1:0] I = 2'b00, R = 2'b01, W = 2'b10, RW = 2'b11;

  typedef struct {
    bit [1:0]    op0;
    logic [15:0] a0;
    logic [3:0]  be0;
    logic [31:0] d0;
    bit [1:0]    op1;
    logic [15:0] a1;
    logic [3:0]  be1;
    logic [31:0] d1;
    bit          stl, clr, rst;
    bit          w0, w1, cs, mw;
    bit          v0;
    logic [31:0] rd0;
    bit          v1;
    logic [31:0] rd1;
    bit          ef;
    logic [7:0]  ec;
  } vec_t;

  logic clk = 0;
  logic reset;
  logic [15:0] m0_address, m1_address, mem_address;
  logic [3:0]  m0_byteenable, m1_byteenable, mem_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, mem_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_readdata = 32'h0;
  logic        stall, err_flag, err_clear;
  logic [7:0]  err_count;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] last_ad = 16'h0;
  vec_t vecs[$];
  logic [31:0] mem_arr [0:51199];

  always #5 clk = ~clk;

  sopc4_memory_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
    .stall(stall), .err_flag(err_flag), .err_count(err_count), .err_clear(err_clear)
  );

  // Single-port RAM, one-cycle registered read, byte-lane writes.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) mem_arr[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= mem_arr[mem_address];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL vec %0d %s: got %h expected %h", n_vec, name, act, exp_v);
    end
  endtask

  task automatic add(input vec_t v);
    vecs.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    bit          gexp;
    logic [15:0] exp_ad;
    @(negedge clk);
    reset = v.rst; stall = v.stl; err_clear = v.clr;
    m0_read = v.op0[0]; m0_write = v.op0[1]; m0_address = v.a0;
    m0_byteenable = v.be0; m0_writedata = v.d0;
    m1_read = v.op1[0]; m1_write = v.op1[1]; m1_address = v.a1;
    m1_byteenable = v.be1; m1_writedata = v.d1;
    #1;
    n_vec++;
    gexp   = !v.w0 || !v.w1;
    exp_ad = !gexp ? last_ad : (!v.w0 ? v.a0 : v.a1);
    chk("m0_waitrequest", m0_waitrequest, v.w0);
    chk("m1_waitrequest", m1_waitrequest, v.w1);
    chk("mem_chipselect", mem_chipselect, v.cs);
    chk("mem_write", mem_write, v.mw);
    chk("mem_address", mem_address, exp_ad);
    chk("mem_clken", mem_clken, !v.stl || v.v0 || v.v1);
    chk("m0_readdatavalid", m0_readdatavalid, v.v0);
    chk("m0_readdata", m0_readdata, v.rd0);
    chk("m1_readdatavalid", m1_readdatavalid, v.v1);
    chk("m1_readdata", m1_readdata, v.rd1);
    chk("err_flag", err_flag, v.ef);
    chk("err_count", err_count, v.ec);
    last_ad = v.rst ? 16'h0 : exp_ad;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    for (int i = 0; i < 51200; i++) mem_arr[i] = 32'h0;
    reset = 1; stall = 0; err_clear = 0;
    m0_read = 0; m0_write = 0; m0_address = 0; m0_byteenable = 0; m0_writedata = 0;
    m1_read = 0; m1_write = 0; m1_address = 0; m1_byteenable = 0; m1_writedata = 0;
    repeat (3) @(posedge clk);

    //   op0 a0 be0 d0, op1 a1 be1 d1, stl clr rst, w0 w1 cs mw, v0 rd0, v1 rd1, ef ec
    add('{I,0,0,0, I,0,0,0, 0,0,0, 1,1,0,0, 0,0,0,0, 0,0});
    add('{W,16'h0010,4'hF,32'hDEADBEEF, I,0,0,0, 0,0,0, 0,1,1,1, 0,0,0,0, 0,0});
    add('{R,16'h0010,4'hF,0, I,0,0,0, 0,0,0, 0,1,1,0, 0,0,0,0, 0,0});
    add('{I,0,0,0, W,16'h0011,4'hF,32'hCAFE0001, 0,0,0, 1,0,1,1, 1,32'hDEADBEEF,0,0, 0,0});
    for (int i = 0; i < 6; i++)
      add('{R,16'h0010,4'hF,0, R,16'h0011,4'hF,0, 0,0,0,
            (i % 2 == 1), (i % 2 == 0), 1, 0,
            (i % 2 == 1), (i % 2 == 1) ? 32'hDEADBEEF : 32'h0,
            (i > 0 && i % 2 == 0), (i > 0 && i % 2 == 0) ? 32'hCAFE0001 : 32'h0, 0,0});
    add('{I,0,0,0, I,0,0,0, 0,0,0, 1,1,0,0, 0,0,1,32'hCAFE0001, 0,0});
    add('{I,0,0,0, W,16'h0020,4'hF,32'hFFFFFFFF, 0,0,0, 1,0,1,1, 0,0,0,0, 0,0});
    add('{I,0,0,0, W,16'h0020,4'h3,32'h12345678, 0,0,0, 1,0,1,1, 0,0,0,0, 0,0});
    add('{I,0,0,0, R,16'h0020,4'hF,0, 0,0,0, 1,0,1,0, 0,0,0,0, 0,0});
    add('{I,0,0,0, I,0,0,0, 0,0,0, 1,1,0,0, 0,0,1,32'hFFFF5678, 0,0});
    add('{RW,16'h0030,4'hF,32'hA5A5A5A5, I,0,0,0, 0,0,0, 0,1,1,1, 0,0,0,0, 0,0});
    add('{R,16'h0030,4'hF,0, I,0,0,0, 0,0,0, 0,1,1,0, 0,0,0,0, 0,0});
    add('{I,0,0,0, I,0,0,0, 0,0,0, 1,1,0,0, 1,32'hA5A5A5A5,0,0, 0,0});
    add('{R,16'hC800,4'hF,0, I,0,0,0, 0,0,0, 0,1,0,0, 0,0,0,0, 0,0});
    add('{I,0,0,0, W,16'hFFFF,4'hF,32'h11111111, 0,0,0, 1,0,0,0, 1,0,0,0, 1,1});
    add('{I,0,0,0, I,0,0,0, 0,0,0, 1,1,0,0, 0,0,0,0, 1,2});
    add('{W,16'hC7FF,4'hF,32'h0BADF00D, I,0,0,0, 0,0,0, 0,1,1,1, 0,0,0,0, 1,2});
    add('{R,16'hC7FF,4'hF,0, I,0,0,0, 0,0,0, 0,1,1,0, 0,0,0,0, 1,2});
    add('{I,0,0,0, I,0,0,0, 0,0,0, 1,1,0,0, 1,32'h0BADF00D,0,0, 1,2});
    foreach (vecs[i]) apply(vecs[i]);

    // Back-to-back out-of-range reads drive the counter into saturation.
    for (int i = 0; i < 300; i++) begin
      v = '{R,16'hC800,4'hF,0, I,0,0,0, 0,0,0, 0,1,0,0, (i > 0),0,0,0, 1,
            (i + 2 > 255) ? 8'hFF : 8'(i + 2)};
      apply(v);
    end
    apply('{R,16'hC800,4'hF,0, I,0,0,0, 0,1,0, 0,1,0,0, 1,0,0,0, 1,8'hFF});
    apply('{I,0,0,0, I,0,0,0, 0,0,0, 1,1,0,0, 1,0,0,0, 0,0});

    // Read accepted just before stall completes under stall; m0 wins after release.
    apply('{I,0,0,0, R,16'h0011,4'hF,0, 0,0,0, 1,0,1,0, 0,0,0,0, 0,0});
    apply('{R,16'h0010,4'hF,0, R,16'h0011,4'hF,0, 1,0,0, 1,1,0,0, 0,0,1,32'hCAFE0001, 0,0});
    apply('{R,16'h0010,4'hF,0, R,16'h0011,4'hF,0, 1,0,0, 1,1,0,0, 0,0,0,0, 0,0});
    apply('{R,16'h0010,4'hF,0, R,16'h0011,4'hF,0, 1,0,0, 1,1,0,0, 0,0,0,0, 0,0});
    apply('{R,16'h0010,4'hF,0, R,16'h0011,4'hF,0, 0,0,0, 0,1,1,0, 0,0,0,0, 0,0});
    apply('{I,0,0,0, R,16'h0011,4'hF,0, 0,0,0, 1,0,1,0, 1,32'hDEADBEEF,0,0, 0,0});
    apply('{I,0,0,0, I,0,0,0, 0,0,0, 1,1,0,0, 0,0,1,32'hCAFE0001, 0,0});

    // Reset right after a read accept: return dropped, m0 wins afterwards.
    apply('{R,16'h0010,4'hF,0, I,0,0,0, 0,0,0, 0,1,1,0, 0,0,0,0, 0,0});
    apply('{I,0,0,0, I,0,0,0, 0,0,1, 1,1,0,0, 0,0,0,0, 0,0});
    apply('{I,0,0,0, I,0,0,0, 0,0,0, 1,1,0,0, 0,0,0,0, 0,0});
    apply('{R,16'h0010,4'hF,0, R,16'h0011,4'hF,0, 0,0,0, 0,1,1,0, 0,0,0,0, 0,0});
    apply('{I,0,0,0, R,16'h0011,4'hF,0, 0,0,0, 1,0,1,0, 1,32'hDEADBEEF,0,0, 0,0});
    apply('{I,0,0,0, I,0,0,0, 0,0,0, 1,1,0,0, 0,0,1,32'hCAFE0001, 0,0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
